maxpool2d_stride_2: RTL and testbench

Streaming 2x2, stride-2 max-pooling stage for IEEE-754 single-precision feature maps, placed directly after a 3x3 convolution stage in the VGG16 datapath. It consumes the convolution's raster-order pixel stream (data, valid) and emits one pooled pixel per 2x2 window, (IMG_WIDTH/2) x (IMG_HEIGHT/2) per frame. A single half-width row buffer holds the partial maxima of even rows. An optional fused ReLU is applied at the output.

---
 rtl/maxpool2d_stride_2.sv | 162 ++++++++++++++++
 tb/tb_maxpool2d_stride_2.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2d_stride_2.sv
// -----------------------------------------------------------------------------
// maxpool2d_stride_2
//
// Streaming 2x2, stride-2 max-pooling stage for FP32 feature maps. It consumes
// a raster-order pixel stream and emits one pooled pixel per 2x2 window.
// Partial maxima of even rows are kept in a half-width row buffer, and the
// odd row of each row pair finishes the window against them.
//
// Optional feature (compile-time macro):
//   MAXPOOL_FUSED_RELU_EN - when defined, a ReLU is applied ahead of the output
//                           register. Any result with the sign bit set,
//                           including -0, becomes +0.
//
// Parameters:
//   DATA_WIDTH - pixel width; only 32 (FP32) is supported
//   IMG_WIDTH  - input frame width; must be even
//   IMG_HEIGHT - input frame height; must be even
//
// Ports:
//   clk             - clock
//   resetn          - asynchronous, active-low reset
//   data_valid_in   - input pixel qualifier; gaps allowed
//   data_in         - input pixel, raster order
//   data_out        - pooled pixel (registered); holds between results
//   valid_out_pixel - one-cycle qualifier for data_out
//   done            - pulses with valid_out_pixel on the last pooled pixel of
//                     a frame
// -----------------------------------------------------------------------------
module maxpool2d_stride_2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 56,
    parameter int IMG_HEIGHT = 56
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out_pixel,
    output logic                  done
);

    localparam int HALF_W = IMG_WIDTH / 2;
    localparam int NOUT   = (IMG_WIDTH / 2) * (IMG_HEIGHT / 2);
    localparam int CW     = $clog2(IMG_WIDTH);
    localparam int RW     = $clog2(IMG_HEIGHT);
    localparam int RBW    = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam int OCW    = (NOUT > 1) ? $clog2(NOUT) : 1;

    // Elaboration-time parameter checks.
    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("maxpool2d_stride_2: DATA_WIDTH must be 32 (FP32)");
    end
    if ((IMG_WIDTH % 2) != 0 || IMG_WIDTH < 2) begin : g_bad_width
        $error("maxpool2d_stride_2: IMG_WIDTH must be even");
    end
    if ((IMG_HEIGHT % 2) != 0 || IMG_HEIGHT < 2) begin : g_bad_height
        $error("maxpool2d_stride_2: IMG_HEIGHT must be even");
    end

    // Map a sign-magnitude float onto a two's-complement ordering key.
    // Both zeros map to 0, so -0 and +0 compare equal. NaN/Inf are not
    // special-cased and simply order by their bit pattern.
    function automatic logic signed [DATA_WIDTH-1:0] order_key(
        input logic [DATA_WIDTH-1:0] v
    );
        logic signed [DATA_WIDTH-1:0] mag;
        mag = $signed({1'b0, v[DATA_WIDTH-2:0]});
        return v[DATA_WIDTH-1] ? -mag : mag;
    endfunction

    // The later operand replaces the earlier one only if strictly greater,
    // so ties keep the earlier-arriving value.
    function automatic logic [DATA_WIDTH-1:0] fp_max(
        input logic [DATA_WIDTH-1:0] earlier,
        input logic [DATA_WIDTH-1:0] later
    );
        return (order_key(later) > order_key(earlier)) ? later : earlier;
    endfunction

    logic [CW-1:0]         col;
    logic [RW-1:0]         row;
    logic [DATA_WIDTH-1:0] hold;
    logic [DATA_WIDTH-1:0] rowbuf [HALF_W];
    logic [OCW-1:0]        ocnt;

    logic                  col_last;
    logic                  row_last;
    logic                  ocnt_last;
    logic                  window_end;
    logic [RBW-1:0]        rb_idx;
    logic [DATA_WIDTH-1:0] pair_max;
    logic [DATA_WIDTH-1:0] pool_max;
    logic [DATA_WIDTH-1:0] out_val;

    assign col_last   = (col == CW'(IMG_WIDTH - 1));
    assign row_last   = (row == RW'(IMG_HEIGHT - 1));
    assign ocnt_last  = (ocnt == OCW'(NOUT - 1));
    assign rb_idx     = RBW'(col >> 1);
    assign window_end = data_valid_in & col[0] & row[0];

    // Horizontal pair: the held even-column pixel arrived first.
    assign pair_max = fp_max(hold, data_in);
    // Vertical merge: the even-row partial in rowbuf arrived first.
    assign pool_max = fp_max(rowbuf[rb_idx], pair_max);

`ifdef MAXPOOL_FUSED_RELU_EN
    assign out_val = pool_max[DATA_WIDTH-1] ? '0 : pool_max;
`else
    assign out_val = pool_max;
`endif

    // Raster position and horizontal hold register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col  <= '0;
            row  <= '0;
            hold <= '0;
        end else if (data_valid_in) begin
            if (!col[0]) begin
                hold <= data_in;
            end
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Even-row partial maxima, consumed by the odd row of the same pair.
    // NOTE: the row buffer has no reset; each entry is always written during
    // the even row before the odd row reads it, and leaving it out of reset
    // lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (data_valid_in && col[0] && !row[0]) begin
            rowbuf[rb_idx] <= pair_max;
        end
    end

    // Output register, single-cycle strobes and output counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out        <= '0;
            valid_out_pixel <= 1'b0;
            done            <= 1'b0;
            ocnt            <= '0;
        end else if (window_end) begin
            data_out        <= out_val;
            valid_out_pixel <= 1'b1;
            done            <= ocnt_last;
            ocnt            <= ocnt_last ? '0 : ocnt + OCW'(1);
        end else begin
            valid_out_pixel <= 1'b0;
            done            <= 1'b0;
        end
    end

endmodule

// File: tb/tb_maxpool2d_stride_2.sv
// -----------------------------------------------------------------------------
// tb_maxpool2d_stride_2
//
// Directed bench for maxpool2d_stride_2. One instance is built for 4x4 frames,
// a second for 2x2 frames. Inputs change on the falling edge; outputs are
// sampled on the next falling edge, so every cycle checks that valid/done are
// high exactly one clock after a window-completing pixel and that data_out
// holds its value otherwise.
// -----------------------------------------------------------------------------
module tb_maxpool2d_stride_2;

    logic        clk = 1'b0;
    logic        resetn;

    logic        dv4;
    logic [31:0] din4;
    logic [31:0] dout4;
    logic        vo4;
    logic        done4;

    logic        dv2;
    logic [31:0] din2;
    logic [31:0] dout2;
    logic        vo2;
    logic        done2;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_out [2];

    always #5 clk = ~clk;

    maxpool2d_stride_2 #(.DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_dut4 (
        .clk             (clk),
        .resetn          (resetn),
        .data_valid_in   (dv4),
        .data_in         (din4),
        .data_out        (dout4),
        .valid_out_pixel (vo4),
        .done            (done4)
    );

    maxpool2d_stride_2 #(.DATA_WIDTH(32), .IMG_WIDTH(2), .IMG_HEIGHT(2)) u_dut2 (
        .clk             (clk),
        .resetn          (resetn),
        .data_valid_in   (dv2),
        .data_in         (din2),
        .data_out        (dout2),
        .valid_out_pixel (vo2),
        .done            (done2)
    );

    // Stimulus tables (hand-encoded FP32 constants).
    logic [31:0] ramp [16] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
        32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
        32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
        32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
    };
    logic [31:0] ramp_exp [4] = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};

    logic [31:0] ramp2 [16] = '{
        32'h41880000, 32'h41900000, 32'h41980000, 32'h41A00000,
        32'h41A80000, 32'h41B00000, 32'h41B80000, 32'h41C00000,
        32'h41C80000, 32'h41D00000, 32'h41D80000, 32'h41E00000,
        32'h41E80000, 32'h41F00000, 32'h41F80000, 32'h42000000
    };
    logic [31:0] ramp2_exp [4] = '{32'h41B00000, 32'h41C00000, 32'h41F00000, 32'h42000000};

    logic [31:0] neg [16] = '{
        32'hBF800000, 32'hC0000000, 32'hC0400000, 32'hC0800000,
        32'hC0A00000, 32'hC0C00000, 32'hC0E00000, 32'hC1000000,
        32'hC1100000, 32'hC1200000, 32'hC1300000, 32'hC1400000,
        32'hC1500000, 32'hC1600000, 32'hC1700000, 32'hC1800000
    };
`ifdef MAXPOOL_FUSED_RELU_EN
    logic [31:0] neg_exp [4] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
    localparam logic [31:0] TIE_A_EXP = 32'h00000000;
`else
    logic [31:0] neg_exp [4] = '{32'hBF800000, 32'hC0400000, 32'hC1100000, 32'hC1300000};
    localparam logic [31:0] TIE_A_EXP = 32'h80000000;
`endif
    localparam logic [31:0] TIE_B_EXP = 32'h00000000;

    // Idle cycles inserted before each pixel in the gapped run.
    int gaps [16] = '{1, 0, 2, 0, 0, 1, 0, 2, 1, 0, 0, 1, 2, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic cycle(input bit sel, input bit v, input logic [31:0] d,
                         input bit trig, input logic [31:0] exp_d, input bit exp_done);
        logic [31:0] o_d;
        logic        o_v;
        logic        o_done;
        if (sel) begin
            dv2 = v; din2 = d; dv4 = 1'b0;
        end else begin
            dv4 = v; din4 = d; dv2 = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        o_d    = sel ? dout2 : dout4;
        o_v    = sel ? vo2   : vo4;
        o_done = sel ? done2 : done4;
        if (trig) last_out[sel] = exp_d;
        check(sel ? "valid2" : "valid4", {31'd0, o_v}, {31'd0, trig});
        check(sel ? "done2" : "done4", {31'd0, o_done}, {31'd0, exp_done});
        check(sel ? "data2" : "data4", o_d, last_out[sel]);
    endtask

    // Streams the first npx pixels of a 4x4 frame; pixels 5, 7, 13, 15 close
    // a window, and the fourth window closes the frame.
    task automatic frame4(input logic [31:0] px [16], input logic [31:0] ex [4],
                          input bit gapped, input int npx);
        int k = 0;
        bit trig;
        for (int i = 0; i < npx; i++) begin
            if (gapped) begin
                for (int g = 0; g < gaps[i]; g++) cycle(1'b0, 1'b0, 32'hDEADBEEF, 1'b0, '0, 1'b0);
            end
            trig = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            cycle(1'b0, 1'b1, px[i], trig, trig ? ex[k] : 32'h0, trig && (k == 3));
            if (trig) k++;
        end
        dv4 = 1'b0;
    endtask

    task automatic frame2(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] d,
                          input logic [31:0] exp);
        cycle(1'b1, 1'b1, a, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, b, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, c, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, d, 1'b1, exp, 1'b1);
        dv2 = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data4"}, dout4, 32'h0);
        check({tag, "_valid4"}, {31'd0, vo4}, 32'h0);
        check({tag, "_done4"}, {31'd0, done4}, 32'h0);
        check({tag, "_data2"}, dout2, 32'h0);
        check({tag, "_valid2"}, {31'd0, vo2}, 32'h0);
        check({tag, "_done2"}, {31'd0, done2}, 32'h0);
    endtask

    initial begin
        resetn = 1'b0;
        dv4 = 1'b0; din4 = '0;
        dv2 = 1'b0; din2 = '0;
        last_out[0] = '0;
        last_out[1] = '0;

        @(negedge clk);
        check_reset_outputs("rst");
        resetn = 1'b1;

        // Ascending ramp, continuous valid.
        frame4(ramp, ramp_exp, 1'b0, 16);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b0);

        // Descending negative ramp.
        frame4(neg, neg_exp, 1'b0, 16);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b0);

        // Signed-zero ties on the 2x2 instance, back to back.
        frame2(32'h80000000, 32'h00000000, 32'h80000000, 32'h80000000, TIE_A_EXP);
        frame2(32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, TIE_B_EXP);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, '0, 1'b0);

        // Ramp with gaps in data_valid_in.
        frame4(ramp, ramp_exp, 1'b1, 16);

        // Two back-to-back frames with no idle cycle.
        frame4(ramp, ramp_exp, 1'b0, 16);
        frame4(ramp2, ramp2_exp, 1'b0, 16);

        // Abort a frame after 7 pixels, then run a fresh frame.
        frame4(ramp, ramp_exp, 1'b0, 7);
        resetn = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst_hold");
        resetn = 1'b1;
        last_out[0] = '0;
        last_out[1] = '0;
        frame4(ramp, ramp_exp, 1'b0, 16);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
